// File: rtl/bexkat1Def.sv
// Shared bexkat1 definitions used by the memory stage: instruction types,
// memory-stage states and access-width codes.
package bexkat1Def;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } memstate_t;

  typedef enum logic [3:0] {
    T_INH    = 4'h0,
    T_PUSH   = 4'h1,
    T_POP    = 4'h2,
    T_CMP    = 4'h3,
    T_MOV    = 4'h4,
    T_INTU   = 4'h5,
    T_INTS   = 4'h6,
    T_FPU    = 4'h7,
    T_FP     = 4'h8,
    T_ALU    = 4'h9,
    T_INT    = 4'ha,
    T_LDI    = 4'hb,
    T_LOAD   = 4'hc,
    T_STORE  = 4'hd,
    T_BRANCH = 4'he,
    T_JUMP   = 4'hf
  } insttype_t;

  localparam logic [1:0] MEM_W32 = 2'b00;
  localparam logic [1:0] MEM_W16 = 2'b01;
  localparam logic [1:0] MEM_W8  = 2'b10;

  function automatic logic is_mem(input insttype_t t);
    return (t == T_LOAD) || (t == T_STORE);
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane logic for the memory stage (big-endian, sel[3] = byte 0):
// lane selects, store data replication and zero-extended load extraction.
module mem_lane
  import bexkat1Def::*;
(
  input  logic [1:0]  width_i,
  input  logic [1:0]  adr_i,
  input  logic [31:0] st_dat_i,
  input  logic [31:0] ld_dat_i,
  output logic [3:0]  sel_o,
  output logic [31:0] st_dat_o,
  output logic [31:0] ld_res_o
);

  logic [31:0] byte_sh_s;

  // byte 0 lives in the top lane, so shift by (3 - adr) bytes
  assign byte_sh_s = ld_dat_i >> {~adr_i, 3'b000};

  always_comb begin
    sel_o    = 4'hf;
    st_dat_o = st_dat_i;
    ld_res_o = ld_dat_i;
    case (width_i)
      MEM_W16: begin
        sel_o    = adr_i[1] ? 4'b0011 : 4'b1100;
        st_dat_o = {2{st_dat_i[15:0]}};
        ld_res_o = {16'h0000, (adr_i[1] ? ld_dat_i[15:0] : ld_dat_i[31:16])};
      end
      MEM_W8: begin
        sel_o    = 4'b1000 >> adr_i;
        st_dat_o = {4{st_dat_i[7:0]}};
        ld_res_o = {24'h000000, byte_sh_s[7:0]};
      end
      default: begin
        sel_o    = 4'hf;
        st_dat_o = st_dat_i;
        ld_res_o = ld_dat_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// bexkat1 memory stage: runs load/store bus cycles, passes other instructions through.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access
  import bexkat1Def::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] result_i,
  input  logic [31:0] reg_data1_i,
  input  logic [1:0]  reg_write_i,
  input  logic        stall_i,
  output logic        stall_o,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic [31:0] result_o,
  output logic [1:0]  reg_write_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  output logic        exc_o
);

  memstate_t   state_q, state_d;
  logic [63:0] ir_q, ir_d, cap_ir_q, cap_ir_d;
  logic [31:0] pc_q, pc_d, cap_pc_q, cap_pc_d;
  logic [31:0] res_q, res_d, cap_res_q, cap_res_d;
  logic [1:0]  rw_q, rw_d, cap_rw_q, cap_rw_d;
  logic        cap_st_q, cap_st_d, done_q, done_d;
  logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;

  insttype_t   type_s;
  logic [1:0]  lane_w_s, lane_a_s;
  logic [3:0]  lane_sel_s;
  logic [31:0] lane_st_s, lane_ld_s, bus_res_s;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exc_q, exc_d;
  assign exc_o = exc_q;
`else
  assign exc_o = 1'b0;
`endif

  assign type_s  = insttype_t'(ir_i[31:28]);
  assign stall_o = stall_i | (state_q == S_BUS);

  // the lane unit sees the incoming instruction while idle, the captured one during a bus cycle
  assign lane_w_s  = (state_q == S_IDLE) ? ir_i[25:24]   : cap_ir_q[25:24];
  assign lane_a_s  = (state_q == S_IDLE) ? result_i[1:0] : cap_res_q[1:0];
  assign bus_res_s = cap_st_q ? cap_res_q : lane_ld_s;

  mem_lane u_lane (
    .width_i  (lane_w_s),
    .adr_i    (lane_a_s),
    .st_dat_i (reg_data1_i),
    .ld_dat_i (bus_dat_i),
    .sel_o    (lane_sel_s),
    .st_dat_o (lane_st_s),
    .ld_res_o (lane_ld_s)
  );

  // stage FSM: next state, capture registers, bus request and pipeline outputs
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    res_d     = res_q;
    rw_d      = rw_q;
    cap_ir_d  = cap_ir_q;
    cap_pc_d  = cap_pc_q;
    cap_res_d = cap_res_q;
    cap_rw_d  = cap_rw_q;
    cap_st_d  = cap_st_q;
    done_d    = done_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
    exc_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (stall_i) begin
          state_d = S_IDLE;
        end else if (is_mem(type_s)) begin
          cap_ir_d  = ir_i;
          cap_pc_d  = pc_i;
          cap_res_d = result_i;
          cap_rw_d  = reg_write_i;
          cap_st_d  = (type_s == T_STORE);
          done_d    = 1'b0;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          we_d      = (type_s == T_STORE);
          adr_d     = {result_i[31:2], 2'b00};
          sel_d     = lane_sel_s;
          dat_d     = lane_st_s;
          ir_d      = 64'h0;
          rw_d      = 2'b00;
          state_d   = S_BUS;
`ifdef MEM_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else begin
          ir_d  = ir_i;
          pc_d  = pc_i;
          res_d = result_i;
          rw_d  = reg_write_i;
        end
      end
      S_BUS: begin
        // done_q: access finished under stall, result parked in cap_res_q
        if (done_q) begin
          if (stall_i) begin
            state_d = S_BUS;
          end else begin
            ir_d    = cap_ir_q;
            pc_d    = cap_pc_q;
            res_d   = cap_res_q;
            rw_d    = cap_rw_q;
            done_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else if (bus_ack_i) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          we_d      = 1'b0;
          cap_res_d = bus_res_s;
          if (stall_i) begin
            done_d = 1'b1;
          end else begin
            ir_d    = cap_ir_q;
            pc_d    = cap_pc_q;
            res_d   = bus_res_s;
            rw_d    = cap_rw_q;
            state_d = S_IDLE;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          exc_d   = 1'b1;
          rw_d    = 2'b00;
          ir_d    = cap_ir_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        else begin
          state_d = S_BUS;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      ir_q      <= 64'h0;
      pc_q      <= 32'h0;
      res_q     <= 32'h0;
      rw_q      <= 2'b00;
      cap_ir_q  <= 64'h0;
      cap_pc_q  <= 32'h0;
      cap_res_q <= 32'h0;
      cap_rw_q  <= 2'b00;
      cap_st_q  <= 1'b0;
      done_q    <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 32'h0;
      sel_q     <= 4'h0;
      dat_q     <= 32'h0;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= '0;
      exc_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      res_q     <= res_d;
      rw_q      <= rw_d;
      cap_ir_q  <= cap_ir_d;
      cap_pc_q  <= cap_pc_d;
      cap_res_q <= cap_res_d;
      cap_rw_q  <= cap_rw_d;
      cap_st_q  <= cap_st_d;
      done_q    <= done_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= cnt_d;
      exc_q     <= exc_d;
`endif
    end
  end

  assign ir_o        = ir_q;
  assign pc_o        = pc_q;
  assign result_o    = res_q;
  assign reg_write_o = rw_q;
  assign bus_cyc_o   = cyc_q;
  assign bus_stb_o   = stb_q;
  assign bus_we_o    = we_q;
  assign bus_adr_o   = adr_q;
  assign bus_sel_o   = sel_q;
  assign bus_dat_o   = dat_q;

endmodule
